// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer_pkg
// Purpose  : Shared state encoding and serial frame length for bit_serializer.
// Revision : 1.0
// ============================================================================
package bit_serializer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_SHIFT = 3'b010;
    localparam logic [2:0] ST_GAP   = 3'b100;

    // Serial frame length: data bits plus the optional trailing parity bit.
    function automatic int calc_nbits(input int width);
`ifdef BIT_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/ser_gap_timer.sv
`default_nettype none
// ============================================================================
// Module   : ser_gap_timer
// Purpose  : Loadable down-counter; o_done is high during the last counted cycle.
// Revision : 1.0
// ============================================================================
module ser_gap_timer #(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_done
);

    localparam int              CW       = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
    localparam logic [CW-1:0]   c_LOAD   = CW'(CYCLES);
    localparam logic [CW-1:0]   c_ONE    = CW'(1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_LOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_done = (r_count == c_ONE);

endmodule
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-to-serial front end for the 101 detector; optional even
//            parity bit when BIT_SERIALIZER_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy
);

    localparam int            NBITS      = calc_nbits(WIDTH);
    localparam int            CW         = $clog2(NBITS + 1);
    localparam logic [CW-1:0] c_CNT_LOAD = CW'(NBITS);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(1);

    logic [2:0]       r_state;
    logic [NBITS-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_ser_bit;
    logic             r_ser_valid;

    logic [WIDTH-1:0] w_data_ord;
    logic [NBITS-1:0] w_frame;
    logic             w_last;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_gap_done;

    // w_data_ord holds the word with its first transmitted bit at the MSB.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_data_ord = in_data;
        end else begin : g_lsb_first
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
                assign w_data_ord[gi] = in_data[WIDTH-1-gi];
            end
        end
    endgenerate

`ifdef BIT_SERIALIZER_PARITY_EN
    assign w_frame = {w_data_ord, ^in_data};
`else
    assign w_frame = w_data_ord;
`endif

    assign w_last     = (r_state == ST_SHIFT) && (r_cnt == c_CNT_LAST);
    assign w_in_ready = !rst && ((r_state == ST_IDLE) || (w_last && (GAP_CYCLES == 0)));
    assign w_accept   = in_valid && w_in_ready;

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            ser_gap_timer #(
                .CYCLES (GAP_CYCLES)
            ) u_gap_timer (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_last),
                .o_done (w_gap_done)
            );
        end else begin : g_no_gap
            assign w_gap_done = 1'b0;
        end
    endgenerate

    // An accept is only possible in IDLE or on the last bit, so it overrides the state step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
        end else if (w_accept) begin
            r_state     <= ST_SHIFT;
            r_ser_bit   <= w_frame[NBITS-1];
            r_ser_valid <= 1'b1;
            r_shift     <= w_frame << 1;
            r_cnt       <= c_CNT_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ser_bit   <= 1'b0;
                    r_ser_valid <= 1'b0;
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_ser_bit <= r_shift[NBITS-1];
                        r_shift   <= r_shift << 1;
                        r_cnt     <= r_cnt - c_CNT_LAST;
                    end else begin
                        r_state     <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                        r_ser_bit   <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_shift     <= '0;
                        r_cnt       <= '0;
                    end
                end
                ST_GAP: begin
                    if (w_gap_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ser_bit   <= 1'b0;
                    r_ser_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign ser_bit   = r_ser_bit;
    assign ser_valid = r_ser_valid;
    assign busy      = r_state[1] | r_state[2];

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Self-checking bench; three instances (MSB/no gap, LSB first, gap=3).
// Revision : 1.0
// ============================================================================
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int c_NB = 9;
`else
    localparam int c_NB = 8;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid  [3];
    logic [7:0] in_data   [3];
    logic       in_ready  [3];
    logic       ser_bit   [3];
    logic       ser_valid [3];
    logic       busy      [3];

    bit         exp_q    [3][$];
    logic [7:0] pend     [3][$];
    int         gap_left [3];

    int checks   = 0;
    int failures = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]), .busy(busy[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]), .busy(busy[1]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(3)) u_dut_c (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .ser_bit(ser_bit[2]), .ser_valid(ser_valid[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gap_of(input int i);
        return (i == 2) ? 3 : 0;
    endfunction

    task automatic push_word(input int i, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            exp_q[i].push_back((i == 1) ? w[k] : w[7-k]);
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        exp_q[i].push_back(^w);
`endif
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            pend[i].delete();
            gap_left[i] = 0;
            in_valid[i] = 1'b0;
        end
    endtask

    // Called just after a falling edge: check every instance, drive, advance one clock.
    task automatic step();
        bit acc [3];
        for (int i = 0; i < 3; i++) begin
            bit e_valid, e_busy, e_ready, eb;
            e_valid = (exp_q[i].size() != 0);
            e_busy  = e_valid || (gap_left[i] != 0);
            e_ready = !e_busy || ((exp_q[i].size() == 1) && (gap_of(i) == 0));
            checks++;
            if (ser_valid[i] !== e_valid) begin
                failures++;
                $display("FAIL ser_valid[%0d] t=%0t got=%b exp=%b", i, $time, ser_valid[i], e_valid);
            end
            checks++;
            if (busy[i] !== e_busy) begin
                failures++;
                $display("FAIL busy[%0d] t=%0t got=%b exp=%b", i, $time, busy[i], e_busy);
            end
            checks++;
            if (in_ready[i] !== e_ready) begin
                failures++;
                $display("FAIL in_ready[%0d] t=%0t got=%b exp=%b", i, $time, in_ready[i], e_ready);
            end
            if (e_valid) begin
                eb = exp_q[i].pop_front();
                if ((exp_q[i].size() == 0) && (gap_of(i) > 0)) gap_left[i] = gap_of(i);
            end else begin
                eb = 1'b0;
                if (gap_left[i] > 0) gap_left[i]--;
            end
            checks++;
            if (ser_bit[i] !== eb) begin
                failures++;
                $display("FAIL ser_bit[%0d] t=%0t got=%b exp=%b", i, $time, ser_bit[i], eb);
            end
            acc[i] = 1'b0;
            if (pend[i].size() != 0) begin
                in_valid[i] = 1'b1;
                in_data[i]  = pend[i][0];
                acc[i]      = e_ready;
            end else begin
                in_valid[i] = 1'b0;
                in_data[i]  = 8'($urandom);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) push_word(i, pend[i].pop_front());
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_drained(input string name);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ((pend[i].size() != 0) || (exp_q[i].size() != 0)) begin
                failures++;
                $display("FAIL drained_%s[%0d] got pend=%0d bits=%0d exp=0/0",
                         name, i, pend[i].size(), exp_q[i].size());
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready[i], ser_bit[i], ser_valid[i], busy[i]} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outs[%0d] got=%b%b%b%b exp=0000",
                         i, in_ready[i], ser_bit[i], ser_valid[i], busy[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_reset[%0d] got=%b exp=1", i, in_ready[i]);
            end
        end
        run(2);
    endtask

    task automatic test_single();
        pend[0].push_back(8'b1010_0000);
        run(c_NB + 4);
        check_drained("single");
    endtask

    task automatic test_back_to_back();
        pend[0].push_back(8'hA5);
        pend[0].push_back(8'h5A);
        run(2 * c_NB + 4);
        check_drained("b2b");
    endtask

    task automatic test_lsb_first();
        pend[1].push_back(8'h01);
        pend[1].push_back(8'h07);
        run(2 * c_NB + 4);
        check_drained("lsb");
    endtask

    task automatic test_gap();
        pend[2].push_back(8'hA5);
        pend[2].push_back(8'h3C);
        run(2 * c_NB + 3 + 6);
        check_drained("gap");
    endtask

    task automatic test_parity_word();
        pend[0].push_back(8'h07);
        pend[2].push_back(8'h07);
        run(c_NB + 5);
        check_drained("word07");
    endtask

    task automatic test_mid_word_reset();
        pend[0].push_back(8'hFF);
        run(4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ser_valid[0], ser_bit[0], busy[0], in_ready[0]} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b%b%b%b exp=0000",
                     ser_valid[0], ser_bit[0], busy[0], in_ready[0]);
        end
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_midreset got=%b exp=1", in_ready[0]);
        end
        run(c_NB + 3);
        check_drained("midreset");
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_gap();
        test_parity_word();
        test_mid_word_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
